// File: rtl/alu_seq_controller.sv
// Moore sequencer driving the regfile/ALU datapath one multi-cycle
// command at a time; all control outputs are registered.
module alu_seq_controller #(
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [RW-1:0] rn,
    input  logic [RW-1:0] rm,
    input  logic [RW-1:0] rd,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    ALUop,
    output logic          loadc,
    output logic          loads,
    output logic          vsel
);

    typedef enum logic [2:0] {
        IDLE, LDA, LDB, EXEC, WB, DONE
    } state_t;

    localparam logic [2:0] OP_MOVI = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_MVN  = 3'd4;
    localparam logic [2:0] OP_CMP  = 3'd5;
    localparam logic [2:0] OP_MOVR = 3'd6;
    localparam logic [2:0] OP_BAD  = 3'd7;

    state_t        st, nst;
    logic [2:0]    cop, nop;
    logic [RW-1:0] crn, nrn, crm, nrm, crd, nrd;

    logic          n_busy, n_done, n_err;
    logic [RW-1:0] n_readnum, n_writenum;
    logic          n_write, n_loada, n_loadb;
    logic          n_asel, n_bsel, n_loadc, n_loads, n_vsel;
    logic [1:0]    n_aluop;

    always_comb begin
        nst = IDLE;
        nop = cop;
        nrn = crn;
        nrm = crm;
        nrd = crd;
        case (st)
            IDLE: begin
                if (start) begin
                    nop = op;
                    nrn = rn;
                    nrm = rm;
                    nrd = rd;
                    case (op)
                        OP_MOVI:                        nst = WB;
                        OP_ADD, OP_SUB, OP_AND, OP_CMP: nst = LDA;
                        OP_MVN, OP_MOVR:                nst = LDB;
                        default:                        nst = DONE;
                    endcase
                end
            end
            LDA:     nst = LDB;
            LDB:     nst = EXEC;
            EXEC:    nst = (cop == OP_CMP) ? DONE : WB;
            WB:      nst = DONE;
            default: nst = IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they line up
    // with that state once registered.
    always_comb begin
        n_busy     = (nst != IDLE);
        n_done     = 1'b0;
        n_err      = 1'b0;
        n_readnum  = '0;
        n_writenum = '0;
        n_write    = 1'b0;
        n_loada    = 1'b0;
        n_loadb    = 1'b0;
        n_asel     = 1'b0;
        n_bsel     = 1'b0;
        n_aluop    = 2'b00;
        n_loadc    = 1'b0;
        n_loads    = 1'b0;
        n_vsel     = 1'b0;
        case (nst)
            LDA: begin
                n_readnum = nrn;
                n_loada   = 1'b1;
            end
            LDB: begin
                n_readnum = nrm;
                n_loadb   = 1'b1;
            end
            EXEC: begin
                n_loadc = (nop != OP_CMP);
                n_loads = (nop != OP_MOVR);
                n_asel  = (nop == OP_MVN) || (nop == OP_MOVR);
                case (nop)
                    OP_SUB, OP_CMP: n_aluop = 2'b01;
                    OP_AND:         n_aluop = 2'b10;
                    OP_MVN:         n_aluop = 2'b11;
                    default:        n_aluop = 2'b00;
                endcase
            end
            WB: begin
                n_writenum = nrd;
                n_write    = 1'b1;
                n_vsel     = (nop == OP_MOVI);
            end
            DONE: begin
                n_done = 1'b1;
                n_err  = (nop == OP_BAD);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= IDLE;
            cop      <= '0;
            crn      <= '0;
            crm      <= '0;
            crd      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            readnum  <= '0;
            writenum <= '0;
            write    <= 1'b0;
            loada    <= 1'b0;
            loadb    <= 1'b0;
            asel     <= 1'b0;
            bsel     <= 1'b0;
            ALUop    <= 2'b00;
            loadc    <= 1'b0;
            loads    <= 1'b0;
            vsel     <= 1'b0;
        end else begin
            st       <= nst;
            cop      <= nop;
            crn      <= nrn;
            crm      <= nrm;
            crd      <= nrd;
            busy     <= n_busy;
            done     <= n_done;
            err      <= n_err;
            readnum  <= n_readnum;
            writenum <= n_writenum;
            write    <= n_write;
            loada    <= n_loada;
            loadb    <= n_loadb;
            asel     <= n_asel;
            bsel     <= n_bsel;
            ALUop    <= n_aluop;
            loadc    <= n_loadc;
            loads    <= n_loads;
            vsel     <= n_vsel;
        end
    end

endmodule

// File: tb/tb_alu_seq_controller.sv
// Bench for alu_seq_controller: command table, corner sequences and
// random commands checked against a path-based reference model.
module tb_alu_seq_controller;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic [1:0] aluop;
        logic       loadc;
        logic       loads;
        logic       vsel;
    } outs_t;

    typedef struct {
        logic [2:0] op;
        logic [2:0] rn;
        logic [2:0] rm;
        logic [2:0] rd;
        int         lat;
        int         writes;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic reset, start;
    logic [2:0] op, rn, rm, rd;
    logic busy, done, err, write, loada, loadb;
    logic asel, bsel, loadc, loads, vsel;
    logic [2:0] readnum, writenum;
    logic [1:0] ALUop;
    outs_t dut_o;

    int nchk = 0;
    int npass = 0;

    alu_seq_controller #(.RW(3)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rn(rn), .rm(rm), .rd(rd), .busy(busy), .done(done),
        .err(err), .readnum(readnum), .writenum(writenum),
        .write(write), .loada(loada), .loadb(loadb), .asel(asel),
        .bsel(bsel), .ALUop(ALUop), .loadc(loadc), .loads(loads),
        .vsel(vsel)
    );

    always #5 clk = ~clk;

    assign dut_o = {busy, done, err, readnum, writenum, write,
                    loada, loadb, asel, bsel, ALUop, loadc, loads,
                    vsel};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Steps: A=read rn into A, B=read rm into B, X=ALU, W=writeback, D=done
    function automatic string path_of(input logic [2:0] o);
        case (o)
            3'd0:             return "WD";
            3'd1, 3'd2, 3'd3: return "ABXWD";
            3'd4, 3'd6:       return "BXWD";
            3'd5:             return "ABXD";
            default:          return "D";
        endcase
    endfunction

    function automatic outs_t step_out(input byte s, input logic [2:0] o,
                                       input logic [2:0] a,
                                       input logic [2:0] b,
                                       input logic [2:0] d);
        outs_t r = '0;
        r.busy = 1'b1;
        case (s)
            "A": begin r.readnum = a; r.loada = 1'b1; end
            "B": begin r.readnum = b; r.loadb = 1'b1; end
            "X": begin
                r.loadc = (o != 3'd5);
                r.loads = (o != 3'd6);
                r.asel  = (o == 3'd4) || (o == 3'd6);
                if (o == 3'd2 || o == 3'd5) r.aluop = 2'b01;
                else if (o == 3'd3)         r.aluop = 2'b10;
                else if (o == 3'd4)         r.aluop = 2'b11;
                else                        r.aluop = 2'b00;
            end
            "W": begin
                r.writenum = d;
                r.write    = 1'b1;
                r.vsel     = (o == 3'd0);
            end
            default: begin r.done = 1'b1; r.err = (o == 3'd7); end
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1 with the DUT idle; leaves it idle the same way.
    task automatic run_cmd(input logic [2:0] o, input logic [2:0] a,
                           input logic [2:0] b, input logic [2:0] d,
                           input string nm, output int lat,
                           output int nw);
        string p;
        outs_t e;
        p = path_of(o);
        lat = 0;
        nw = 0;
        start = 1'b1; op = o; rn = a; rm = b; rd = d;
        for (int k = 0; k < p.len(); k++) begin
            tick();
            e = step_out(p[k], o, a, b, d);
            chk($sformatf("%s cyc%0d", nm, k + 1), 32'(dut_o), 32'(e));
            if (done && lat == 0) lat = k + 1;
            if (write) nw++;
            if (k < p.len() - 1) begin
                start = 1'($urandom);
                op = 3'($urandom); rn = 3'($urandom);
                rm = 3'($urandom); rd = 3'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        tick();
        chk($sformatf("%s idle", nm), 32'(dut_o), 32'd0);
    endtask

    vec_t tbl[8];

    initial begin
        int lat, nw, seen;
        tbl[0] = '{3'd1, 3'd1, 3'd2, 3'd3, 5, 1, "ADD"};
        tbl[1] = '{3'd0, 3'd0, 3'd0, 3'd5, 2, 1, "MOVI"};
        tbl[2] = '{3'd5, 3'd4, 3'd4, 3'd0, 4, 0, "CMP"};
        tbl[3] = '{3'd6, 3'd0, 3'd6, 3'd0, 4, 1, "MOVR"};
        tbl[4] = '{3'd4, 3'd0, 3'd7, 3'd1, 4, 1, "MVN"};
        tbl[5] = '{3'd7, 3'd2, 3'd3, 3'd4, 1, 0, "ILL"};
        tbl[6] = '{3'd2, 3'd7, 3'd5, 3'd6, 5, 1, "SUB"};
        tbl[7] = '{3'd3, 3'd3, 3'd1, 3'd2, 5, 1, "AND"};

        reset = 1'b1; start = 1'b1;
        op = 3'd1; rn = 3'd1; rm = 3'd2; rd = 3'd3;
        tick(); tick();
        chk("reset outs", 32'(dut_o), 32'd0);
        reset = 1'b0; start = 1'b0;
        tick();
        chk("post-reset idle", 32'(dut_o), 32'd0);

        foreach (tbl[i]) begin
            run_cmd(tbl[i].op, tbl[i].rn, tbl[i].rm, tbl[i].rd,
                    tbl[i].name, lat, nw);
            chk({tbl[i].name, " latency"}, 32'(lat), 32'(tbl[i].lat));
            chk({tbl[i].name, " writes"}, 32'(nw), 32'(tbl[i].writes));
        end

        // start held high: one SUB, an idle gap, then the next accept
        start = 1'b1; op = 3'd2; rn = 3'd1; rm = 3'd2; rd = 3'd3;
        for (int k = 0; k < 5; k++) tick();
        chk("hold done", 32'(done), 32'd1);
        tick();
        chk("hold gap", 32'(dut_o), 32'd0);
        tick();
        chk("hold 2nd lda", 32'({busy, loada}), 32'b11);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            tick();
            if (done) seen = k + 2;
        end
        chk("hold 2nd done cyc", 32'(seen), 32'd5);
        tick();

        // reset during EXEC abandons the command
        start = 1'b1; op = 3'd2; rn = 3'd4; rm = 3'd5; rd = 3'd6;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("rst exec loadc", 32'({loadc, ALUop}), 32'b101);
        reset = 1'b1;
        tick();
        chk("rst abandon", 32'(dut_o), 32'd0);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (write || done || busy) seen++;
        end
        chk("rst no pulse", 32'(seen), 32'd0);
        run_cmd(3'd1, 3'd2, 3'd3, 3'd4, "ADD after rst", lat, nw);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] o, a, b, d;
            o = 3'($urandom); a = 3'($urandom);
            b = 3'($urandom); d = 3'($urandom);
            run_cmd(o, a, b, d, $sformatf("rnd%0d", i), lat, nw);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/alu_seq_controller.md
Name: alu_seq_controller

Overview:
Moore FSM that sequences the register-file / ALU datapath through one multi-cycle operation per command. It drives readnum, loada, loadb, asel, bsel, ALUop, loadc, loads, vsel, writenum and write, so a command (op, Rn, Rm, Rd) executes without hand-driven control. It sits between the command source (bench or future decoder) and the datapath.

Parameters:
RW, 3, register address width (readnum / writenum / rn / rm / rd)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
start  input  1  command valid; sampled only in IDLE
op  input  3  command opcode (encoding below)
rn  input  RW  A-operand register
rm  input  RW  B-operand register
rd  input  RW  destination register
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse in DONE state
err  output  1  high with done when op was illegal
readnum  output  RW  regfile read address
writenum  output  RW  regfile write address
write  output  1  regfile write enable
loada  output  1  A register load
loadb  output  1  B register load
asel  output  1  1 = force ALU A input to 0
bsel  output  1  1 = ALU B from immediate path
ALUop  output  2  00 add, 01 sub, 10 and, 11 not-B
loadc  output  1  C register load
loads  output  1  status (Z) register load
vsel  output  1  1 = writeback from external datapath_in

Behaviour:
- States: IDLE, LDA, LDB, EXEC, WB, DONE. One state per cycle, no waits.
- IDLE & start=1: latch op/rn/rm/rd into internal regs at that edge; next state per op. start ignored in every other state (no queuing).
- Opcodes and paths:
  000 MOVI: IDLE->WB(vsel=1)->DONE
  001 ADD, 010 SUB, 011 AND: IDLE->LDA->LDB->EXEC->WB->DONE
  100 MVN: IDLE->LDB->EXEC->WB->DONE
  101 CMP: IDLE->LDA->LDB->EXEC->DONE (no writeback)
  110 MOVR: IDLE->LDB->EXEC->WB->DONE (Rd = 0 + Rm)
  111 illegal: IDLE->DONE, err=1; no enable asserted
- Per-state outputs (decoded from state + latched command only; inputs never affect outputs combinationally):
  LDA: readnum=rn, loada=1
  LDB: readnum=rm, loadb=1
  EXEC: loadc=1 except CMP; loads=1 for ADD/SUB/AND/MVN/CMP, 0 for MOVR; ALUop: ADD 00, SUB 01, AND 10, MVN 11, CMP 01, MOVR 00; asel=1 for MOVR and MVN, else 0; bsel=0
  WB: writenum=rd, write=1, vsel=1 for MOVI else 0
  DONE: done=1, err per op; all enables 0; next state IDLE
- Default for any output not listed in a state: 0 (readnum/writenum 0).
- Latency start-edge to done: MOVI 2, ADD/SUB/AND 5, MVN/MOVR 4, CMP 4, illegal 1 cycle.
- write asserted exactly one cycle per writing command; loadc/loads at most one cycle per command.
- start in DONE cycle ignored; earliest accept is the following IDLE cycle, so back-to-back commands have one IDLE gap.
- Latched command is stable from accept through DONE; changing op/rn/rm/rd inputs mid-command has no effect.
- Reset: at any edge with reset=1, state=IDLE, latched regs=0, all outputs 0 next cycle, regardless of state; an in-flight command is abandoned (no write/done afterward). reset overrides start in the same cycle.
- Illegal state encodings recover to IDLE on the next edge.

Test Plan:
- ADD rn=1 rm=2 rd=3 start one cycle -> LDA readnum=1 loada=1; LDB readnum=2 loadb=1; EXEC ALUop=00 loadc=1 loads=1; WB writenum=3 write=1 vsel=0; done at cycle 5; busy high cycles 1-5.
- MOVI rd=5 -> cycle 1 write=1 writenum=5 vsel=1, cycle 2 done=1, no loada/loadb/loadc ever.
- CMP rn=4 rm=4 -> EXEC ALUop=01 loads=1 loadc=0; write never asserted; done at cycle 4.
- MOVR rm=6 rd=0 and MVN rm=7 rd=1 -> EXEC asel=1 loads 0/1 respectively, ALUop 00/11; WB writenum 0/1; done at cycle 4.
- op=111 -> done=1 err=1 at cycle 1, all enables 0; start held high through a SUB -> exactly one command executed until IDLE, second accepted only after IDLE gap.
- Reset asserted in EXEC of SUB -> next cycle IDLE, busy=0, write and done never pulse; subsequent ADD executes normally.
